// File: rtl/riscv_pkg.sv
// Shared RISC-V core types: register index, the zero register and the issue request bundle.
package riscv_pkg;

  localparam int unsigned NUM_REGS  = 64;
  localparam int unsigned REG_IDX_W = $clog2(NUM_REGS);
  localparam int unsigned XLEN      = 32;

  typedef logic [5:0] regidx_t;

  localparam regidx_t REG_ZERO = 6'd0;

  typedef struct packed {
    regidx_t rs1;
    regidx_t rs2;
    regidx_t rd;
    logic    rd_en;
  } regfile_req_t;

endpackage

// File: rtl/riscv_regfile_scoreboard.sv
// Busy-bit scoreboard: tracks in-flight destinations, computes issue readiness and flags
// write-backs that retire a register nobody allocated.
module riscv_regfile_scoreboard
  import riscv_pkg::*;
#(
  parameter int unsigned NUM_REGS = 64
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                req_vld,
  input  regfile_req_t        req,
  input  logic                wb_en,
  input  regidx_t             wb_idx,
  output logic                req_rdy,
  output logic [NUM_REGS-1:0] busy,
  output logic                sb_err
);

  logic [NUM_REGS-1:0] busy_q, busy_d;
  logic                sb_err_q, sb_err_d;
  logic                haz1, haz2, hazd, accept, wb_live;

  // A write-back landing this cycle resolves the hazard it would otherwise cause.
  always_comb begin
    haz1    = busy_q[req.rs1] && !(wb_en && (wb_idx == req.rs1));
    haz2    = busy_q[req.rs2] && !(wb_en && (wb_idx == req.rs2));
    hazd    = req.rd_en && busy_q[req.rd] && !(wb_en && (wb_idx == req.rd));
    req_rdy = !haz1 && !haz2 && !hazd;
    accept  = req_vld && req_rdy;
    wb_live = wb_en && (wb_idx != REG_ZERO);
  end

  // Clear first, then set, so a same-cycle retire/allocate of one index leaves it busy.
  always_comb begin
    busy_d = busy_q;
    if (wb_live) busy_d[wb_idx] = 1'b0;
    if (accept && req.rd_en && (req.rd != REG_ZERO)) busy_d[req.rd] = 1'b1;
    sb_err_d = wb_live && !busy_q[wb_idx];
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      busy_q   <= '0;
      sb_err_q <= 1'b0;
    end else begin
      busy_q   <= busy_d;
      sb_err_q <= sb_err_d;
    end
  end

  assign busy   = busy_q;
  assign sb_err = sb_err_q;

endmodule

// File: rtl/riscv_regfile_sb.sv
// Architectural register file with issue scoreboard; returns operands one cycle after
// acceptance, forwarding same-cycle write-back data.
module riscv_regfile_sb
  import riscv_pkg::*;
#(
  parameter int unsigned NUM_REGS = 64,
  parameter int unsigned XLEN     = 32
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                req_vld,
  output logic                req_rdy,
  input  regidx_t             req_rs1,
  input  regidx_t             req_rs2,
  input  regidx_t             req_rd,
  input  logic                req_rd_en,
  output logic                rsp_vld,
  output logic [XLEN-1:0]     rs1_data,
  output logic [XLEN-1:0]     rs2_data,
  input  logic                register_write_en,
  input  regidx_t             register_write,
  input  logic [XLEN-1:0]     register_write_data,
  output logic [NUM_REGS-1:0] busy,
  output logic                sb_err
);

  regfile_req_t    req;
  logic [XLEN-1:0] mem_q [NUM_REGS];
  logic            rsp_vld_q;
  logic [XLEN-1:0] rs1_q, rs2_q, rs1_d, rs2_d;
  logic            accept;

  assign req = '{rs1: req_rs1, rs2: req_rs2, rd: req_rd, rd_en: req_rd_en};

  riscv_regfile_scoreboard #(
    .NUM_REGS (NUM_REGS)
  ) u_scoreboard (
    .clock   (clock),
    .reset   (reset),
    .req_vld (req_vld),
    .req     (req),
    .wb_en   (register_write_en),
    .wb_idx  (register_write),
    .req_rdy (req_rdy),
    .busy    (busy),
    .sb_err  (sb_err)
  );

  assign accept = req_vld && req_rdy;

  function automatic logic [XLEN-1:0] operand(regidx_t idx, logic [XLEN-1:0] stored);
    if (idx == REG_ZERO) return '0;
    if (register_write_en && (register_write == idx)) return register_write_data;
    return stored;
  endfunction

  always_comb begin
    rs1_d = rs1_q;
    rs2_d = rs2_q;
    if (accept) begin
      rs1_d = operand(req_rs1, mem_q[req_rs1]);
      rs2_d = operand(req_rs2, mem_q[req_rs2]);
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_REGS; i++) mem_q[i] <= '0;
    end else if (register_write_en && (register_write != REG_ZERO)) begin
      mem_q[register_write] <= register_write_data;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rsp_vld_q <= 1'b0;
      rs1_q     <= '0;
      rs2_q     <= '0;
    end else begin
      rsp_vld_q <= accept;
      rs1_q     <= rs1_d;
      rs2_q     <= rs2_d;
    end
  end

  assign rsp_vld  = rsp_vld_q;
  assign rs1_data = rs1_q;
  assign rs2_data = rs2_q;

endmodule

// File: tb/tb_riscv_regfile_sb.sv
// Directed bench for riscv_regfile_sb: expected operands are queued at issue and checked
// by a monitor whenever rsp_vld is seen.
module tb_riscv_regfile_sb;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        req_vld = 1'b0;
  logic        req_rdy;
  logic [5:0]  req_rs1 = '0, req_rs2 = '0, req_rd = '0;
  logic        req_rd_en = 1'b0;
  logic        rsp_vld;
  logic [31:0] rs1_data, rs2_data;
  logic        register_write_en = 1'b0;
  logic [5:0]  register_write = '0;
  logic [31:0] register_write_data = '0;
  logic [63:0] busy;
  logic        sb_err;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
  } exp_t;

  exp_t q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  riscv_regfile_sb dut (
    .clock               (clock),
    .reset               (reset),
    .req_vld             (req_vld),
    .req_rdy             (req_rdy),
    .req_rs1             (req_rs1),
    .req_rs2             (req_rs2),
    .req_rd              (req_rd),
    .req_rd_en           (req_rd_en),
    .rsp_vld             (rsp_vld),
    .rs1_data            (rs1_data),
    .rs2_data            (rs2_data),
    .register_write_en   (register_write_en),
    .register_write      (register_write),
    .register_write_data (register_write_data),
    .busy                (busy),
    .sb_err              (sb_err)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  always @(negedge clock) begin
    if (rsp_vld === 1'b1) begin
      if (q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL rsp_unexpected: got rsp_vld=1, expected no response");
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("rs1_data", 64'(rs1_data), 64'(e.a));
        chk("rs2_data", 64'(rs2_data), 64'(e.b));
      end
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic drive_req(input logic [5:0] rs1, input logic [5:0] rs2,
                           input logic [5:0] rd, input logic rd_en);
    req_vld   = 1'b1;
    req_rs1   = rs1;
    req_rs2   = rs2;
    req_rd    = rd;
    req_rd_en = rd_en;
  endtask

  task automatic issue(input logic [5:0] rs1, input logic [5:0] rs2, input logic [5:0] rd,
                       input logic rd_en, input logic [31:0] e1, input logic [31:0] e2);
    drive_req(rs1, rs2, rd, rd_en);
    #1;
    chk("req_rdy_issue", 64'(req_rdy), 64'd1);
    q.push_back('{a: e1, b: e2});
    tick();
    req_vld = 1'b0;
  endtask

  task automatic wb(input logic [5:0] idx, input logic [31:0] data);
    register_write_en   = 1'b1;
    register_write      = idx;
    register_write_data = data;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) tick();
    reset = 1'b0;
    chk("reset_rsp_vld", 64'(rsp_vld), 64'd0);
    chk("reset_rs1", 64'(rs1_data), 64'd0);
    chk("reset_busy", busy, 64'd0);
    chk("reset_sb_err", 64'(sb_err), 64'd0);

    // Reset then read.
    issue(6'd5, 6'd0, 6'd0, 1'b0, 32'h0, 32'h0);
    chk("read_busy", busy, 64'd0);

    // Write-back to a non-busy register pulses sb_err.
    wb(6'd7, 32'hDEADBEEF);
    tick();
    register_write_en = 1'b0;
    chk("sb_err_pulse", 64'(sb_err), 64'd1);
    tick();
    chk("sb_err_clear", 64'(sb_err), 64'd0);
    issue(6'd7, 6'd0, 6'd0, 1'b0, 32'hDEADBEEF, 32'h0);

    // RAW stall, resolved by same-cycle write-back with bypass.
    issue(6'd0, 6'd0, 6'd3, 1'b1, 32'h0, 32'h0);
    chk("busy3_set", busy, 64'h8);
    drive_req(6'd0, 6'd3, 6'd0, 1'b0);
    #1;
    chk("raw_stall", 64'(req_rdy), 64'd0);
    tick();
    chk("raw_hold", 64'(req_rdy), 64'd0);
    wb(6'd3, 32'h12345678);
    #1;
    chk("raw_release", 64'(req_rdy), 64'd1);
    q.push_back('{a: 32'h0, b: 32'h12345678});
    tick();
    req_vld = 1'b0;
    register_write_en = 1'b0;
    chk("busy3_clear", busy, 64'd0);
    chk("raw_sb_err", 64'(sb_err), 64'd0);

    // WAW stall and set-wins on the same index.
    issue(6'd0, 6'd0, 6'd9, 1'b1, 32'h0, 32'h0);
    chk("busy9_set", busy, 64'h200);
    drive_req(6'd0, 6'd0, 6'd9, 1'b1);
    #1;
    chk("waw_stall", 64'(req_rdy), 64'd0);
    wb(6'd9, 32'hA5);
    #1;
    chk("waw_release", 64'(req_rdy), 64'd1);
    q.push_back('{a: 32'h0, b: 32'h0});
    tick();
    req_vld = 1'b0;
    register_write_en = 1'b0;
    chk("set_wins_busy", busy, 64'h200);
    chk("set_wins_sb_err", 64'(sb_err), 64'd0);
    wb(6'd9, 32'h66);
    tick();
    register_write_en = 1'b0;
    chk("busy9_clear", busy, 64'd0);
    chk("wb9_sb_err", 64'(sb_err), 64'd0);
    issue(6'd9, 6'd0, 6'd0, 1'b0, 32'h66, 32'h0);

    // Index 0 is never written and never allocated.
    wb(6'd0, 32'hFFFFFFFF);
    issue(6'd0, 6'd0, 6'd0, 1'b1, 32'h0, 32'h0);
    register_write_en = 1'b0;
    chk("x0_sb_err", 64'(sb_err), 64'd0);
    chk("x0_busy", busy, 64'd0);
    issue(6'd0, 6'd7, 6'd0, 1'b0, 32'h0, 32'hDEADBEEF);

    // Back-to-back issue at full throughput.
    issue(6'd7, 6'd3, 6'd0, 1'b0, 32'hDEADBEEF, 32'h12345678);
    issue(6'd9, 6'd3, 6'd12, 1'b1, 32'h66, 32'h12345678);
    chk("busy12_set", busy, 64'h1000);
    tick();

    // Reset arriving while a request is being accepted drops it.
    drive_req(6'd7, 6'd9, 6'd13, 1'b1);
    #2;
    reset = 1'b1;
    #1;
    chk("midrst_rsp_vld", 64'(rsp_vld), 64'd0);
    chk("midrst_rs1", 64'(rs1_data), 64'd0);
    chk("midrst_busy", busy, 64'd0);
    tick();
    req_vld = 1'b0;
    reset = 1'b0;
    chk("midrst_after_rsp", 64'(rsp_vld), 64'd0);
    chk("midrst_after_busy", busy, 64'd0);
    issue(6'd7, 6'd9, 6'd0, 1'b0, 32'h0, 32'h0);

    repeat (3) tick();
    chk("queue_drained", 64'(q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
